// File: rtl/sync_period_timer.sv
// -----------------------------------------------------------------------------
// sync_period_timer
//
// Programmable period timer wrapped around a chain of preset-to-ones
// synchronous up-count cells. The chain is modelled here as a WIDTH-bit
// register whose carry-out (CI & all cells at one) marks the terminal count.
// Terminal count is turned into a reload of the counter, a registered
// one-cycle TC pulse and a sticky IRQ that only ACK or reset clears.
//
// Ports
//   CLK       in   system clock, all state changes on the rising edge
//   RESETL    in   synchronous active-low reset, overrides every other input
//   WR        in   write strobe for the reload register
//   DIN       in   reload value (WIDTH), used when WR=1
//   START     in   load counter from reload value and enter RUN (IDLE only)
//   STOP      in   return to IDLE holding the count; beats START and a wrap
//   ONESHOT   in   1 = drop back to IDLE after the first wrap
//   CI        in   count enable (prescaler tick)
//   ACK       in   clears IRQ (a simultaneous wrap keeps IRQ set)
//   Q         out  current count (WIDTH)
//   TC        out  one-cycle pulse in the cycle after a counted wrap
//   IRQ       out  sticky wrap flag
//   RUN       out  1 while the FSM is in RUN
//   DBG_STATE out  raw FSM state (0 = IDLE, 1 = RUN) for checkers
// -----------------------------------------------------------------------------
module sync_period_timer #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESETL,
  input  logic             WR,
  input  logic [WIDTH-1:0] DIN,
  input  logic             START,
  input  logic             STOP,
  input  logic             ONESHOT,
  input  logic             CI,
  input  logic             ACK,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             IRQ,
  output logic             RUN,
  output logic             DBG_STATE
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_reload_eff;
  logic             r_tc;
  logic             r_irq;
  logic             w_carry_out;
  logic             w_wrap;

  // A write in the same cycle as a load/reload is used immediately.
  assign w_reload_eff = WR ? DIN : r_reload;

  // Ripple carry out of the top cell: every cell is at one and CI is high.
  assign w_carry_out = CI & (&r_q);

  // Next-state and next-count. STOP is checked first so a wrap that
  // coincides with STOP is never counted (no reload, TC or IRQ).
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_wrap      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START && !STOP) begin
          w_q_nxt     = w_reload_eff;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (STOP) begin
          w_state_nxt = S_IDLE;
        end else if (w_carry_out) begin
          w_wrap  = 1'b1;
          w_q_nxt = w_reload_eff;
          if (ONESHOT) begin
            w_state_nxt = S_IDLE;
          end
        end else if (CI) begin
          w_q_nxt = r_q + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETL) begin
      r_state  <= S_IDLE;
      r_q      <= '1;
      r_reload <= '1;
      r_tc     <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_tc    <= w_wrap;
      if (WR) begin
        r_reload <= DIN;
      end
      // Set beats clear when a wrap and ACK land on the same edge.
      if (w_wrap) begin
        r_irq <= 1'b1;
      end else if (ACK) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign Q         = r_q;
  assign TC        = r_tc;
  assign IRQ       = r_irq;
  assign RUN       = (r_state == S_RUN);
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_sync_period_timer.sv
// -----------------------------------------------------------------------------
// tb_sync_period_timer
//
// Drives sync_period_timer (WIDTH=16) through directed scenarios and a
// randomized run. A behavioural model (count value, running flag, reload
// value, tick and interrupt flags) is advanced on every rising edge from the
// same inputs and the DUT outputs are compared #1 after the edge.
// -----------------------------------------------------------------------------
module tb_sync_period_timer;

  localparam int         W    = 16;
  localparam logic [W-1:0] ONES = '1;

  // clock / reset
  logic         CLK = 1'b0;
  logic         RESETL;
  logic         WR;
  logic [W-1:0] DIN;
  logic         START;
  logic         STOP;
  logic         ONESHOT;
  logic         CI;
  logic         ACK;
  logic [W-1:0] Q;
  logic         TC;
  logic         IRQ;
  logic         RUN;
  logic         DBG_STATE;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [W-1:0] m_q;
  logic [W-1:0] m_reload;
  logic         m_run;
  logic         m_tc;
  logic         m_irq;

  always #5 CLK = ~CLK;

  sync_period_timer #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RESETL    (RESETL),
    .WR        (WR),
    .DIN       (DIN),
    .START     (START),
    .STOP      (STOP),
    .ONESHOT   (ONESHOT),
    .CI        (CI),
    .ACK       (ACK),
    .Q         (Q),
    .TC        (TC),
    .IRQ       (IRQ),
    .RUN       (RUN),
    .DBG_STATE (DBG_STATE)
  );

  // Behavioural model of one rising edge, written from the timer's rules:
  // a wrap is a CI tick seen at the maximum count while running and not
  // being stopped; it reloads, raises TC next cycle and sets IRQ.
  task automatic model_edge();
    logic [W-1:0] new_value;
    logic         counted;
    new_value = WR ? DIN : m_reload;
    counted   = m_run && !STOP && CI && (m_q == ONES);
    if (!RESETL) begin
      m_q      = ONES;
      m_reload = ONES;
      m_run    = 1'b0;
      m_tc     = 1'b0;
      m_irq    = 1'b0;
    end else begin
      m_tc = counted;
      if (counted)  m_irq = 1'b1;
      else if (ACK) m_irq = 1'b0;
      if (!m_run) begin
        if (START && !STOP) begin
          m_q   = new_value;
          m_run = 1'b1;
        end
      end else if (STOP) begin
        m_run = 1'b0;
      end else if (counted) begin
        m_q = new_value;
        if (ONESHOT) m_run = 1'b0;
      end else if (CI) begin
        m_q = m_q + 1;
      end
      if (WR) m_reload = DIN;
    end
  endtask

  // driver: one clock edge, model update, settle before sampling
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    RESETL  = 1'b1;
    WR      = 1'b0;
    DIN     = '0;
    START   = 1'b0;
    STOP    = 1'b0;
    ONESHOT = 1'b0;
    CI      = 1'b0;
    ACK     = 1'b0;
  endtask

  task automatic test_reset();
    RESETL = 1'b0;
    step();
    RESETL = 1'b1;
    checks++;
    if ({Q, TC, IRQ, RUN} !== {16'hFFFF, 3'b000}) begin
      errors++;
      $display("FAIL reset_values got=%h exp=%h", {Q, TC, IRQ, RUN}, {16'hFFFF, 3'b000});
    end
    CI = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({Q, TC, IRQ, RUN} !== {m_q, m_tc, m_irq, m_run} || Q !== 16'hFFFF) begin
        errors++;
        $display("FAIL idle_ci_hold got=%h exp=%h", {Q, TC, IRQ, RUN}, {16'hFFFF, 3'b000});
      end
    end
    CI = 1'b0;
  endtask

  task automatic test_continuous();
    int n_tc;
    WR = 1'b1; DIN = 16'hFFFC;
    step();
    WR = 1'b0;
    START = 1'b1; CI = 1'b1;
    step();
    START = 1'b0;
    checks++;
    if (Q !== 16'hFFFC || RUN !== 1'b1) begin
      errors++;
      $display("FAIL cont_start got=%h/%b exp=fffc/1", Q, RUN);
    end
    n_tc = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (TC === 1'b1) n_tc++;
      checks++;
      if ({Q, TC, IRQ, RUN} !== {m_q, m_tc, m_irq, m_run}) begin
        errors++;
        $display("FAIL cont_cycle%0d got=%h exp=%h", i, {Q, TC, IRQ, RUN}, {m_q, m_tc, m_irq, m_run});
      end
    end
    // four-tick period over sixteen ticks: four wraps, IRQ set
    checks++;
    if (n_tc !== 4 || IRQ !== 1'b1) begin
      errors++;
      $display("FAIL cont_period got=tc%0d/irq%b exp=tc4/irq1", n_tc, IRQ);
    end
    CI = 1'b0; STOP = 1'b1;
    step();
    STOP = 1'b0; ACK = 1'b1;
    step();
    ACK = 1'b0;
    checks++;
    if ({RUN, IRQ} !== 2'b00) begin
      errors++;
      $display("FAIL cont_stop_ack got=%b exp=00", {RUN, IRQ});
    end
  endtask

  task automatic test_oneshot();
    int n_tc;
    WR = 1'b1; DIN = 16'hFFFE; ONESHOT = 1'b1;
    step();
    WR = 1'b0; START = 1'b1;
    step();
    START = 1'b0;
    n_tc = 0;
    for (int i = 0; i < 12; i++) begin
      CI = (i % 3 == 2);
      step();
      if (TC === 1'b1) n_tc++;
      checks++;
      if ({Q, TC, IRQ, RUN} !== {m_q, m_tc, m_irq, m_run}) begin
        errors++;
        $display("FAIL oneshot_cycle%0d got=%h exp=%h", i, {Q, TC, IRQ, RUN}, {m_q, m_tc, m_irq, m_run});
      end
    end
    checks++;
    if (n_tc !== 1 || RUN !== 1'b0 || Q !== 16'hFFFE) begin
      errors++;
      $display("FAIL oneshot_end got=tc%0d/run%b/q%h exp=tc1/run0/qfffe", n_tc, RUN, Q);
    end
    CI = 1'b0; ONESHOT = 1'b0; ACK = 1'b1;
    step();
    ACK = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic irq_before;
    WR = 1'b1; DIN = 16'hFFFD;
    step();
    WR = 1'b0; START = 1'b1;
    step();
    START = 1'b0; CI = 1'b1;
    for (int k = 0; k < 8 && Q !== ONES; k++) step();
    checks++;
    if (Q !== ONES) begin
      errors++;
      $display("FAIL sim_wait1_timeout got=%h exp=ffff", Q);
    end
    ACK = 1'b1;
    step();
    ACK = 1'b0; CI = 1'b0;
    checks++;
    if ({TC, IRQ} !== 2'b11 || {Q, TC, IRQ, RUN} !== {m_q, m_tc, m_irq, m_run}) begin
      errors++;
      $display("FAIL ack_on_wrap got=%h exp=%h", {Q, TC, IRQ, RUN}, {16'hFFFD, 3'b111});
    end
    ACK = 1'b1;
    step();
    ACK = 1'b0;
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL ack_later got=%b exp=0", IRQ);
    end
    CI = 1'b1;
    for (int k = 0; k < 8 && Q !== ONES; k++) step();
    checks++;
    if (Q !== ONES) begin
      errors++;
      $display("FAIL sim_wait2_timeout got=%h exp=ffff", Q);
    end
    irq_before = IRQ;
    STOP = 1'b1;
    step();
    STOP = 1'b0; CI = 1'b0;
    checks++;
    if ({Q, TC, IRQ, RUN} !== {16'hFFFF, 1'b0, irq_before, 1'b0} ||
        {Q, TC, IRQ, RUN} !== {m_q, m_tc, m_irq, m_run}) begin
      errors++;
      $display("FAIL stop_on_wrap got=%h exp=%h", {Q, TC, IRQ, RUN}, {16'hFFFF, 1'b0, irq_before, 1'b0});
    end
  endtask

  task automatic test_write_through();
    WR = 1'b1; DIN = 16'hFFFE;
    step();
    WR = 1'b0; START = 1'b1;
    step();
    START = 1'b0; CI = 1'b1;
    for (int k = 0; k < 8 && Q !== ONES; k++) step();
    WR = 1'b1; DIN = 16'h0000;
    step();
    WR = 1'b0;
    checks++;
    if ({Q, TC} !== {16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL write_through got=%h exp=%h", {Q, TC}, {16'h0000, 1'b1});
    end
    repeat (65535) step();
    checks++;
    if ({Q, TC} !== {16'hFFFF, 1'b0} || {Q, TC, IRQ, RUN} !== {m_q, m_tc, m_irq, m_run}) begin
      errors++;
      $display("FAIL full_period_pre got=%h exp=%h", {Q, TC}, {16'hFFFF, 1'b0});
    end
    step();
    checks++;
    if ({Q, TC} !== {16'h0000, 1'b1} || {Q, TC, IRQ, RUN} !== {m_q, m_tc, m_irq, m_run}) begin
      errors++;
      $display("FAIL full_period_wrap got=%h exp=%h", {Q, TC}, {16'h0000, 1'b1});
    end
    CI = 1'b0; STOP = 1'b1;
    step();
    STOP = 1'b0;
  endtask

  task automatic test_reset_mid();
    WR = 1'b1; DIN = 16'hFFFF;
    step();
    WR = 1'b0; START = 1'b1;
    step();
    START = 1'b0; CI = 1'b1;
    step();
    step();
    checks++;
    if ({RUN, IRQ} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_state got=%b exp=11", {RUN, IRQ});
    end
    RESETL = 1'b0; START = 1'b1; WR = 1'b1; DIN = 16'h1234;
    step();
    RESETL = 1'b1; WR = 1'b0; CI = 1'b0;
    checks++;
    if ({Q, TC, IRQ, RUN} !== {16'hFFFF, 3'b000}) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=%h", {Q, TC, IRQ, RUN}, {16'hFFFF, 3'b000});
    end
    step();
    START = 1'b0;
    checks++;
    if ({Q, RUN} !== {16'hFFFF, 1'b1}) begin
      errors++;
      $display("FAIL restart_load got=%h exp=%h", {Q, RUN}, {16'hFFFF, 1'b1});
    end
    CI = 1'b1;
    step();
    CI = 1'b0;
    checks++;
    if ({Q, TC, IRQ, RUN} !== {16'hFFFF, 3'b111}) begin
      errors++;
      $display("FAIL restart_first_ci got=%h exp=%h", {Q, TC, IRQ, RUN}, {16'hFFFF, 3'b111});
    end
    STOP = 1'b1; ACK = 1'b1;
    step();
    STOP = 1'b0; ACK = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      RESETL  = (($urandom_range(0, 63)) != 0);
      WR      = (($urandom_range(0, 7)) == 0);
      DIN     = 16'hFFF0 | 16'($urandom_range(0, 15));
      START   = (($urandom_range(0, 3)) == 0);
      STOP    = (($urandom_range(0, 15)) == 0);
      ONESHOT = 1'($urandom_range(0, 1));
      CI      = (($urandom_range(0, 3)) != 0);
      ACK     = (($urandom_range(0, 7)) == 0);
      step();
      checks++;
      if ({Q, TC, IRQ, RUN} !== {m_q, m_tc, m_irq, m_run}) begin
        errors++;
        $display("FAIL random_cycle%0d got=%h exp=%h", i, {Q, TC, IRQ, RUN}, {m_q, m_tc, m_irq, m_run});
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_q = ONES; m_reload = ONES; m_run = 1'b0; m_tc = 1'b0; m_irq = 1'b0;
    #1;
    test_reset();
    test_continuous();
    test_oneshot();
    test_simultaneous();
    test_write_through();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_period_timer.md
Name: sync_period_timer

Overview:
- Multi-bit programmable period timer built around a chain of preset-to-ones synchronous up-count bit cells. Each cell toggles while its carry-in is high and produces carry-out = CI & Q.
- This block drives the chain's preload and carry-in and consumes its ripple carry-out. It turns terminal count into reload, a one-cycle tick and a sticky interrupt request.
- It sits directly downstream of the counter cells and feeds the interrupt and video/sound timing consumers.

Parameters:
- WIDTH, 16, counter and reload register width in bits (min 2).

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RESETL  input  1  reset; synchronous, active-low.
- WR  input  1  write strobe for the reload register.
- DIN  input  WIDTH  reload value written when WR=1.
- START  input  1  start request; loads the counter from reload and enters RUN.
- STOP  input  1  stop request; returns to IDLE with the count held.
- ONESHOT  input  1  1 = stop after the first wrap; 0 = continuous reload.
- CI  input  1  count enable (prescaler tick); counter advances only when 1 in RUN.
- ACK  input  1  clears IRQ.
- Q  output  WIDTH  current count.
- TC  output  1  registered one-cycle pulse, the cycle after a wrap.
- IRQ  output  1  sticky wrap flag.
- RUN  output  1  1 while in state RUN.

Behaviour:
- Reset (RESETL=0 at a CLK edge):
  - Q = all ones; reload register = all ones.
  - IRQ=0, TC=0, RUN=0, state IDLE.
  - Reset overrides every other input, including mid-count and mid-IRQ.
- Reload register:
  - Loaded from DIN on any cycle with WR=1, in any state.
  - Writing during RUN does not disturb Q; the new value takes effect at the next reload.
- Wrap condition: state RUN, CI=1 and Q = all ones. This equals the carry-out of the top cell.
- Count rules in RUN:
  - CI=1 and no wrap: Q <= Q+1.
  - Wrap: Q <= reload value. If WR=1 in the same cycle, DIN is used (write-through).
  - CI=0: Q holds.
- Period: reload value R gives 2^WIDTH - R CI ticks between wraps. R = all ones wraps on every CI.
- States:
  - IDLE:
    - Q holds.
    - START=1 and STOP=0: Q <= reload value (DIN if WR same cycle); go to RUN.
  - RUN:
    - STOP=1: go to IDLE, Q holds. STOP has priority over a wrap in the same cycle; no TC or IRQ for that wrap.
    - Wrap with ONESHOT=1: Q reloads, go to IDLE.
    - Wrap with ONESHOT=0: Q reloads, stay in RUN.
    - START while in RUN is ignored.
  - START and STOP in the same cycle: STOP wins, and the state is IDLE after the edge.
- TC:
  - Registered; equals 1 exactly in the cycle following a counted wrap, otherwise 0.
  - Back-to-back wraps (R = all ones, CI held high) give TC high continuously.
- IRQ:
  - Set on a counted wrap; cleared on ACK=1.
  - Wrap and ACK in the same cycle: IRQ is 1 after the edge (set wins).
  - IRQ is unaffected by STOP and START; only reset or ACK clears it.
- RUN output equals (state == RUN), registered. Latency: START at edge n gives RUN=1 after edge n.

Test Plan:
- Reset then idle: RESETL low 1 cycle → Q=16'hFFFF, RUN=0, TC=0, IRQ=0. CI pulses in IDLE leave Q unchanged.
- Continuous period:
  - Stimulus: WR DIN=16'hFFFC, START, CI=1 every cycle, ONESHOT=0.
  - Required: Q goes FFFC, FFFD, FFFE, FFFF, FFFC…
  - TC high one cycle after each FFFF→FFFC transition, i.e. every 4 cycles. IRQ set at the first wrap.
- One-shot with sparse CI:
  - Stimulus: DIN=16'hFFFE, ONESHOT=1, CI every 3rd cycle.
  - Required: exactly one TC pulse after 2 CI ticks. RUN drops after the same edge; Q=FFFE afterwards.
- Simultaneous events:
  - ACK coincident with a wrap → IRQ remains 1; a later ACK clears it.
  - STOP coincident with a wrap → no TC, IRQ unchanged, Q=FFFF held, RUN=0.
- Reload write-through: WR DIN=16'h0000 on the wrap cycle → Q=0000 next cycle. Next wrap occurs after 65536 CI ticks (check the Q=FFFF→0000 transition and TC).
- Reset mid-operation: RESETL low while RUN=1 and IRQ=1 → all outputs at reset values next cycle. START without a new WR counts from FFFF, wrapping on the first CI.
